// File: rtl/liteeth_sram_pkg.sv
// Shared defaults and helpers for the liteeth SRAM-backed FIFO.
package liteeth_sram_pkg;

   localparam int BITS_DEFAULT       = 32;
   localparam int WORD_DEPTH_DEFAULT = 384;
   localparam int ADDR_WIDTH_DEFAULT = 9;

   typedef logic [ADDR_WIDTH_DEFAULT:0] occ_t;

   // Depth need not be a power of two, so wrap explicitly.
   function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
      return (ptr == depth - 1) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/liteeth_sram_fifo_outbuf.sv
// Two-entry head/skid buffer that hides the SRAM read latency from the consumer.
module liteeth_sram_fifo_outbuf
   import liteeth_sram_pkg::*;
#(
   parameter int BITS = BITS_DEFAULT
) (
   input  logic            sys_clk,
   input  logic            sys_rst_n,
   input  logic            cap,
   input  logic [BITS-1:0] cap_data,
   input  logic            pop,
   output logic [1:0]      count,
   output logic            rd_valid,
   output logic [BITS-1:0] rd_data
);

   logic [BITS-1:0] skid;
   logic            pop_ok;
   logic [1:0]      count_next;

   assign pop_ok = pop && (count != 2'd0);

   always_comb begin
      count_next = count;
      if (cap && !pop_ok)
         count_next = count + 2'd1;
      else if (!cap && pop_ok)
         count_next = count - 2'd1;
   end

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         count    <= 2'd0;
         rd_valid <= 1'b0;
      end else begin
         count    <= count_next;
         rd_valid <= (count_next != 2'd0);
      end
   end

   // Data registers carry no reset; count alone says which entries are live.
   always_ff @(posedge sys_clk) begin
      if (pop_ok) begin
         if (count == 2'd2) begin
            rd_data <= skid;
            if (cap)
               skid <= cap_data;
         end else if (cap) begin
            rd_data <= cap_data;
         end
      end else if (cap) begin
         if (count == 2'd0)
            rd_data <= cap_data;
         else
            skid <= cap_data;
      end
   end

endmodule

// File: rtl/liteeth_sram_fifo.sv
// FIFO controller driving a 1RW1R SRAM macro; RW port writes, R port reads.
module liteeth_sram_fifo
   import liteeth_sram_pkg::*;
#(
   parameter int BITS       = BITS_DEFAULT,
   parameter int WORD_DEPTH = WORD_DEPTH_DEFAULT,
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEFAULT
) (
   input  logic                  sys_clk,
   input  logic                  sys_rst_n,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   input  logic [BITS-1:0]       wr_data,
   output logic                  rd_valid,
   input  logic                  rd_ready,
   output logic [BITS-1:0]       rd_data,
   output logic [ADDR_WIDTH:0]   level,
   output logic                  mem_rw0_ce,
   output logic                  mem_rw0_we,
   output logic [ADDR_WIDTH-1:0] mem_rw0_addr,
   output logic [BITS-1:0]       mem_rw0_wd,
   output logic                  mem_r0_ce,
   output logic [ADDR_WIDTH-1:0] mem_r0_addr,
   input  logic [BITS-1:0]       mem_r0_rd
);

   localparam int CW = ADDR_WIDTH + 1;

   logic [ADDR_WIDTH-1:0] wptr, rptr;
   logic [CW-1:0]         mem_count, level_next;
   logic                  inflight, wr_fire, pop, fetch;
   logic [1:0]            buf_count;
   logic [2:0]            pending;

   assign wr_fire = wr_valid && wr_ready;
   assign pop     = rd_valid && rd_ready;

   // Words already committed to the buffer, net of this cycle's pop, must leave room.
   assign pending = {1'b0, buf_count} + {2'b0, inflight};
   assign fetch   = (mem_count != '0) && (pending < (3'd2 + {2'b0, pop}));

   assign level_next = level + CW'(wr_fire) - CW'(pop);

   assign mem_rw0_ce   = wr_fire;
   assign mem_rw0_we   = wr_fire;
   assign mem_rw0_addr = wptr;
   assign mem_rw0_wd   = wr_data;
   assign mem_r0_ce    = fetch;
   assign mem_r0_addr  = rptr;

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         wptr      <= '0;
         rptr      <= '0;
         mem_count <= '0;
         inflight  <= 1'b0;
         level     <= '0;
         wr_ready  <= 1'b0;
      end else begin
         if (wr_fire)
            wptr <= ADDR_WIDTH'(ptr_inc(32'(wptr), WORD_DEPTH));
         if (fetch)
            rptr <= ADDR_WIDTH'(ptr_inc(32'(rptr), WORD_DEPTH));
         mem_count <= mem_count + CW'(wr_fire) - CW'(fetch);
         inflight  <= fetch;
         level     <= level_next;
         wr_ready  <= (level_next < CW'(WORD_DEPTH));
      end
   end

   liteeth_sram_fifo_outbuf #(
      .BITS(BITS)
   ) u_outbuf (
      .sys_clk  (sys_clk),
      .sys_rst_n(sys_rst_n),
      .cap      (inflight),
      .cap_data (mem_r0_rd),
      .pop      (pop),
      .count    (buf_count),
      .rd_valid (rd_valid),
      .rd_data  (rd_data)
   );

endmodule

// File: tb/tb_liteeth_sram_fifo.sv
// Scoreboard bench for liteeth_sram_fifo with a behavioural SRAM macro model.
module tb_liteeth_sram_fifo;
   import liteeth_sram_pkg::*;

   localparam int DEPTH = 384;

   logic        sys_clk = 1'b0;
   logic        sys_rst_n;
   logic        wr_valid, wr_ready, rd_valid, rd_ready;
   logic [31:0] wr_data, rd_data;
   occ_t        level;
   logic        mem_rw0_ce, mem_rw0_we, mem_r0_ce;
   logic [8:0]  mem_rw0_addr, mem_r0_addr;
   logic [31:0] mem_rw0_wd, mem_r0_rd;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_q[$];
   int          exp_level = 0;
   bit          prev_rst_low = 1'b1;
   int          acc = 0;
   logic [31:0] sram[DEPTH];

   always #5 sys_clk = ~sys_clk;

   liteeth_sram_fifo dut (
      .sys_clk     (sys_clk),
      .sys_rst_n   (sys_rst_n),
      .wr_valid    (wr_valid),
      .wr_ready    (wr_ready),
      .wr_data     (wr_data),
      .rd_valid    (rd_valid),
      .rd_ready    (rd_ready),
      .rd_data     (rd_data),
      .level       (level),
      .mem_rw0_ce  (mem_rw0_ce),
      .mem_rw0_we  (mem_rw0_we),
      .mem_rw0_addr(mem_rw0_addr),
      .mem_rw0_wd  (mem_rw0_wd),
      .mem_r0_ce   (mem_r0_ce),
      .mem_r0_addr (mem_r0_addr),
      .mem_r0_rd   (mem_r0_rd)
   );

   // SRAM macro: synchronous write, read data valid the cycle after mem_r0_ce.
   always @(posedge sys_clk) begin
      if (mem_rw0_ce && mem_rw0_we && (mem_rw0_addr < DEPTH))
         sram[mem_rw0_addr] <= mem_rw0_wd;
      if (mem_r0_ce)
         mem_r0_rd <= (mem_r0_addr < DEPTH) ? sram[mem_r0_addr] : 32'hDEAD_BEEF;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: compares outputs mid-cycle, pops the scoreboard on each handshake.
   always @(negedge sys_clk) begin
      if (!sys_rst_n) begin
         exp_level    = 0;
         prev_rst_low = 1'b1;
      end else begin
         chk("level", 64'(level), 64'(exp_level));
         chk("wr_ready", 64'(wr_ready), prev_rst_low ? 64'd0 : 64'(exp_level < DEPTH));
         chk("rw_we_without_ce", 64'(mem_rw0_we && !mem_rw0_ce), 64'd0);
         chk("r0_ce_when_empty", 64'(mem_r0_ce && (dut.mem_count == '0)), 64'd0);
         if (rd_valid && rd_ready) begin
            if (exp_q.size() == 0)
               chk("pop_underflow", 64'(exp_q.size()), 64'd1);
            else
               chk("rd_data", 64'(rd_data), 64'(exp_q.pop_front()));
         end
         exp_level    = exp_level + int'(wr_valid && wr_ready) - int'(rd_valid && rd_ready);
         prev_rst_low = 1'b0;
      end
   end

   // Called at posedge+1; a beat offered while wr_ready is high is taken at the next edge.
   task automatic step(input bit wv, input logic [31:0] wd, input bit rr);
      wr_valid = wv;
      wr_data  = wd;
      rd_ready = rr;
      if (wv && wr_ready) begin
         exp_q.push_back(wd);
         acc++;
      end
      @(posedge sys_clk);
      #1;
   endtask

   task automatic drain();
      int g;
      g = 0;
      while ((level != 0 || rd_valid) && g < 2000) begin
         step(1'b0, 32'h0, 1'b1);
         g++;
      end
      chk("drain_timeout", 64'(g < 2000), 64'd1);
      chk("drain_empty", 64'(exp_q.size()), 64'd0);
      rd_ready = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int bubbles;
      int n0;
      int guard;
      sys_rst_n = 1'b0;
      wr_valid  = 1'b0;
      rd_ready  = 1'b0;
      wr_data   = 32'h0;
      repeat (3) @(posedge sys_clk);
      #1;
      chk("rst_wr_ready", 64'(wr_ready), 64'd0);
      chk("rst_rd_valid", 64'(rd_valid), 64'd0);
      chk("rst_level", 64'(level), 64'd0);
      chk("rst_r0_ce", 64'(mem_r0_ce), 64'd0);
      chk("rst_rw0_ce", 64'(mem_rw0_ce), 64'd0);
      sys_rst_n = 1'b1;
      @(posedge sys_clk);
      #1;
      chk("wr_ready_after_rst", 64'(wr_ready), 64'd1);

      // Single word latency
      step(1'b1, 32'hA5A5_0001, 1'b0);
      chk("lat_level_e", 64'(level), 64'd1);
      chk("lat_valid_e", 64'(rd_valid), 64'd0);
      step(1'b0, 32'h0, 1'b0);
      chk("lat_valid_e1", 64'(rd_valid), 64'd0);
      step(1'b0, 32'h0, 1'b0);
      chk("lat_valid_e2", 64'(rd_valid), 64'd1);
      chk("lat_data_e2", 64'(rd_data), 64'hA5A5_0001);
      step(1'b0, 32'h0, 1'b1);
      chk("lat_level_pop", 64'(level), 64'd0);
      chk("lat_valid_pop", 64'(rd_valid), 64'd0);

      // Streaming 1000 words, wraps pointers twice
      bubbles = 0;
      for (int i = 0; i < 1000; i++) begin
         step(1'b1, 32'h1000_0000 + 32'(i), 1'b1);
         if (!wr_ready) bubbles++;
         if (i >= 2 && !rd_valid) bubbles++;
      end
      chk("stream_bubbles", 64'(bubbles), 64'd0);
      drain();

      // Fill to full with no reads
      n0 = acc;
      guard = 0;
      while (wr_ready && guard < 500) begin
         step(1'b1, $urandom, 1'b0);
         guard++;
      end
      chk("full_accepted", 64'(acc - n0), 64'd384);
      chk("full_level", 64'(level), 64'd384);
      chk("full_wr_ready", 64'(wr_ready), 64'd0);
      step(1'b1, $urandom, 1'b1);
      chk("after_pop_wr_ready", 64'(wr_ready), 64'd1);
      chk("after_pop_level", 64'(level), 64'd383);
      drain();

      // Random traffic
      for (int i = 0; i < 10000; i++)
         step(1'(($urandom & 1)), $urandom, 1'(($urandom & 1)));
      drain();

      // Reset while fetching
      for (int i = 0; i < 200; i++)
         step(1'b1, 32'hBAD0_0000 + 32'(i), 1'b0);
      step(1'b0, 32'h0, 1'b1);
      step(1'b0, 32'h0, 1'b1);
      sys_rst_n = 1'b0;
      wr_valid  = 1'b0;
      rd_ready  = 1'b1;
      exp_q.delete();
      @(posedge sys_clk);
      #1;
      sys_rst_n = 1'b1;
      chk("midrst_level", 64'(level), 64'd0);
      chk("midrst_rd_valid", 64'(rd_valid), 64'd0);
      step(1'b0, 32'h0, 1'b0);
      step(1'b0, 32'h0, 1'b0);
      chk("midrst_no_stale", 64'(rd_valid), 64'd0);
      for (int i = 0; i < 8; i++)
         step(1'b1, 32'h600D_0000 + 32'(i), 1'(i[0]));
      wr_valid = 1'b0;
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
